spi_flash_bootrd: RTL and testbench

// - Autonomous SPI-flash read sequencer; sits upstream of the SPI host controller and drives its register port
//   (CTRL/STAT/DATA strobes) in place of the CPU bus.
// - On start: selects flash target, issues READ + 24-bit address, streams len bytes out on a valid/ready byte port.
// - Used for boot-image fetch into SRAM before CPU release.

---
 rtl/spi_bootrd_pkg.sv | 55 +++++
 rtl/spi_bootrd_regif.sv | 76 +++++++
 rtl/spi_flash_bootrd.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_flash_bootrd.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bootrd_pkg.sv
// Shared types and constants for the SPI flash boot reader.
// Build option SPI_BOOTRD_FASTREAD_EN selects FAST READ (0x0B + one dummy byte) instead of READ (0x03).
package spi_bootrd_pkg;

  localparam logic [7:0]  OP_READ      = 8'h03;
  localparam logic [7:0]  OP_FASTREAD  = 8'h0B;
  localparam int unsigned HDR_LEN_READ = 4;
  localparam int unsigned HDR_LEN_FAST = 5;

`ifdef SPI_BOOTRD_FASTREAD_EN
  localparam logic [7:0]  OPCODE  = OP_FASTREAD;
  localparam int unsigned HDR_LEN = HDR_LEN_FAST;
`else
  localparam logic [7:0]  OPCODE  = OP_READ;
  localparam int unsigned HDR_LEN = HDR_LEN_READ;
`endif

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEL,
    ST_HDR,
    ST_DRAIN_POLL,
    ST_DRAIN_RD,
    ST_TXD,
    ST_POLL,
    ST_RXD,
    ST_OUT,
    ST_DESEL,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    RIF_IDLE,
    RIF_STROBE,
    RIF_CAPTURE
  } rif_state_e;

  typedef enum logic [1:0] {
    SEL_CTRL,
    SEL_STAT,
    SEL_DATA
  } reg_sel_e;

  // Header byte idx of the command: opcode, address MSB first, then dummy zeros.
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [23:0] addr);
    case (idx)
      3'd0:    hdr_byte = OPCODE;
      3'd1:    hdr_byte = addr[23:16];
      3'd2:    hdr_byte = addr[15:8];
      3'd3:    hdr_byte = addr[7:0];
      default: hdr_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_bootrd_regif.sv
// Single-access register port sequencer: req (only while idle_o) -> strobe cycle -> capture cycle with ack_o.
// Read data is presented on rdata_o during the ack cycle; no strobe is issued in that cycle.
module spi_bootrd_regif
  import spi_bootrd_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_i,
  input  logic       req_wr_i,
  input  reg_sel_e   req_sel_i,
  input  logic [7:0] req_wd_i,
  output logic       idle_o,
  output logic       ack_o,
  output logic [7:0] rdata_o,
  output rif_state_e state_o,
  output logic [7:0] reg_d_o,
  input  logic [7:0] reg_d_i,
  output logic       reg_wr_o,
  output logic       reg_rd_o,
  output logic       cs_ctrl_o,
  output logic       cs_stat_o,
  output logic       cs_data_o
);

  rif_state_e state_q, state_d;
  logic       wr_q, wr_d;
  reg_sel_e   sel_q, sel_d;
  logic [7:0] wd_q, wd_d;
  logic       strb;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RIF_IDLE;
      wr_q    <= 1'b0;
      sel_q   <= SEL_CTRL;
      wd_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    wd_d    = wd_q;
    case (state_q)
      RIF_IDLE: begin
        if (req_i) begin
          wr_d    = req_wr_i;
          sel_d   = req_sel_i;
          state_d = RIF_STROBE;
          if (req_wr_i) wd_d = req_wd_i;
        end
      end
      RIF_STROBE: state_d = RIF_CAPTURE;
      default:    state_d = RIF_IDLE;
    endcase
  end

  assign strb      = (state_q == RIF_STROBE);
  assign reg_wr_o  = strb & wr_q;
  assign reg_rd_o  = strb & ~wr_q;
  assign cs_ctrl_o = strb & (sel_q == SEL_CTRL);
  assign cs_stat_o = strb & (sel_q == SEL_STAT);
  assign cs_data_o = strb & (sel_q == SEL_DATA);
  assign reg_d_o   = wd_q;
  assign idle_o    = (state_q == RIF_IDLE);
  assign ack_o     = (state_q == RIF_CAPTURE);
  assign rdata_o   = reg_d_i;
  assign state_o   = state_q;

endmodule

// File: rtl/spi_flash_bootrd.sv
// Autonomous SPI-flash read sequencer driving the host controller's CTRL/STAT/DATA register port.
// Byte port: byte_valid_o holds byte_o until byte_ready_i; transfer when both high. Build option: SPI_BOOTRD_FASTREAD_EN.
module spi_flash_bootrd
  import spi_bootrd_pkg::*;
#(
  parameter logic [7:0]  CTRL_SEL_VAL   = 8'h01,
  parameter logic [7:0]  CTRL_DESEL_VAL = 8'h00,
  parameter int unsigned STAT_RXE_BIT   = 0,
  parameter int unsigned POLL_TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [23:0] addr_i,
  input  logic [15:0] len_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic [7:0]  reg_d_o,
  input  logic [7:0]  reg_d_i,
  output logic        reg_wr_o,
  output logic        reg_rd_o,
  output logic        spireg_cs_ctrl_o,
  output logic        spireg_cs_stat_o,
  output logic        spireg_cs_data_o,
  output logic [5:0]  dbg_state_o
);

  localparam int unsigned    PW        = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PW-1:0]  POLL_LAST = PW'(POLL_TIMEOUT - 1);
  localparam logic [2:0]     HDR_LAST  = 3'(HDR_LEN - 1);
  localparam logic [2:0]     RXE_IDX   = 3'(STAT_RXE_BIT);

  state_e        state_q, state_d;
  logic [23:0]   addr_q, addr_d;
  logic [15:0]   rem_q, rem_d;
  logic [2:0]    idx_q, idx_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [7:0]    byte_q, byte_d;
  logic          error_q, error_d;
  logic          ok_q, ok_d;

  logic          rq_valid, rq_wr;
  reg_sel_e      rq_sel;
  logic [7:0]    rq_wd;
  logic          rif_idle, rif_ack, rxe;
  logic [7:0]    rif_rdata;
  rif_state_e    rif_state;

  spi_bootrd_regif u_regif (
    .clk       (clk),
    .resetn    (resetn),
    .req_i     (rq_valid),
    .req_wr_i  (rq_wr),
    .req_sel_i (rq_sel),
    .req_wd_i  (rq_wd),
    .idle_o    (rif_idle),
    .ack_o     (rif_ack),
    .rdata_o   (rif_rdata),
    .state_o   (rif_state),
    .reg_d_o   (reg_d_o),
    .reg_d_i   (reg_d_i),
    .reg_wr_o  (reg_wr_o),
    .reg_rd_o  (reg_rd_o),
    .cs_ctrl_o (spireg_cs_ctrl_o),
    .cs_stat_o (spireg_cs_stat_o),
    .cs_data_o (spireg_cs_data_o)
  );

  assign rxe = rif_rdata[RXE_IDX];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      poll_q  <= '0;
      byte_q  <= '0;
      error_q <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      poll_q  <= poll_d;
      byte_q  <= byte_d;
      error_q <= error_d;
      ok_q    <= ok_d;
    end
  end

  // Access states request only while the regif is idle and act on its ack; abort is checked at each ack.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    poll_d   = poll_q;
    byte_d   = byte_q;
    error_d  = error_q;
    ok_d     = ok_q;
    rq_valid = 1'b0;
    rq_wr    = 1'b0;
    rq_sel   = SEL_CTRL;
    rq_wd    = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d  = addr_i;
          rem_d   = len_i;
          idx_d   = '0;
          poll_d  = '0;
          error_d = 1'b0;
          ok_d    = 1'b0;
          state_d = (len_i == 16'd0) ? ST_DONE : ST_SEL;
        end
      end
      ST_SEL: begin
        rq_valid = rif_idle;
        rq_wr    = 1'b1;
        rq_wd    = CTRL_SEL_VAL;
        if (rif_ack) state_d = abort_i ? ST_DESEL : ST_HDR;
      end
      ST_HDR: begin
        rq_valid = rif_idle;
        rq_wr    = 1'b1;
        rq_sel   = SEL_DATA;
        rq_wd    = hdr_byte(idx_q, addr_q);
        if (rif_ack) begin
          if (abort_i) begin
            state_d = ST_DESEL;
          end else if (idx_q == HDR_LAST) begin
            idx_d   = '0;
            state_d = ST_DRAIN_POLL;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_DRAIN_POLL, ST_POLL: begin
        rq_valid = rif_idle;
        rq_sel   = SEL_STAT;
        if (rif_ack) begin
          if (rxe) begin
            poll_d = poll_q + PW'(1);
            if (poll_q == POLL_LAST) begin
              error_d = 1'b1;
              state_d = ST_DESEL;
            end else if (abort_i) begin
              state_d = ST_DESEL;
            end
          end else begin
            poll_d = '0;
            if (abort_i)                 state_d = ST_DESEL;
            else if (state_q == ST_POLL) state_d = ST_RXD;
            else                         state_d = ST_DRAIN_RD;
          end
        end
      end
      ST_DRAIN_RD: begin
        rq_valid = rif_idle;
        rq_sel   = SEL_DATA;
        if (rif_ack) begin
          if (abort_i) begin
            state_d = ST_DESEL;
          end else if (idx_q == HDR_LAST) begin
            idx_d   = '0;
            state_d = ST_TXD;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_DRAIN_POLL;
          end
        end
      end
      ST_TXD: begin
        rq_valid = rif_idle;
        rq_wr    = 1'b1;
        rq_sel   = SEL_DATA;
        if (rif_ack) state_d = abort_i ? ST_DESEL : ST_POLL;
      end
      ST_RXD: begin
        rq_valid = rif_idle;
        rq_sel   = SEL_DATA;
        if (rif_ack) begin
          byte_d  = rif_rdata;
          state_d = abort_i ? ST_DESEL : ST_OUT;
        end
      end
      ST_OUT: begin
        // A handshake in the abort cycle still counts; otherwise the pending byte is dropped.
        if (byte_ready_i) begin
          rem_d = rem_q - 16'd1;
          if (abort_i) begin
            state_d = ST_DESEL;
          end else if (rem_q == 16'd1) begin
            ok_d    = 1'b1;
            state_d = ST_DESEL;
          end else begin
            state_d = ST_TXD;
          end
        end else if (abort_i) begin
          state_d = ST_DESEL;
        end
      end
      ST_DESEL: begin
        rq_valid = rif_idle;
        rq_wr    = 1'b1;
        rq_wd    = CTRL_DESEL_VAL;
        if (rif_ack) state_d = ok_q ? ST_DONE : ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign error_o      = error_q;
  assign byte_o       = byte_q;
  assign byte_valid_o = (state_q == ST_OUT);
  assign dbg_state_o  = {rif_state, state_q};

endmodule

// File: tb/tb_spi_flash_bootrd.sv
// Directed bench for spi_flash_bootrd with a host-controller register model and a byte consumer.
`timescale 1ns/1ps
module tb_spi_flash_bootrd;

`ifdef SPI_BOOTRD_FASTREAD_EN
  localparam int         HDR_LEN = 5;
  localparam logic [7:0] OPC     = 8'h0B;
`else
  localparam int         HDR_LEN = 4;
  localparam logic [7:0] OPC     = 8'h03;
`endif

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic [23:0] addr_i;
  logic [15:0] len_i;
  logic        abort_i;
  logic        busy_o, done_o, error_o;
  logic [7:0]  byte_o;
  logic        byte_valid_o, byte_ready_i;
  logic [7:0]  reg_d_o, reg_d_i;
  logic        reg_wr_o, reg_rd_o;
  logic        spireg_cs_ctrl_o, spireg_cs_stat_o, spireg_cs_data_o;
  logic [5:0]  dbg_state_o;

  int checks   = 0;
  int failures = 0;

  // Host-controller model state and logs
  logic [7:0] rx_q[$];
  logic [7:0] data_wr_log[$];
  logic [7:0] ctrl_wr_log[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int  empty_left  = 0;
  int  stall_polls = 0;
  bit  dead        = 0;
  int  data_wr_idx = 0;
  int  stat_rd_cnt = 0;
  int  strobe_cnt  = 0;
  int  done_cnt    = 0;
  bit  prev_strobe = 0;

  spi_flash_bootrd dut (
    .clk              (clk),
    .resetn           (resetn),
    .start_i          (start_i),
    .addr_i           (addr_i),
    .len_i            (len_i),
    .abort_i          (abort_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .error_o          (error_o),
    .byte_o           (byte_o),
    .byte_valid_o     (byte_valid_o),
    .byte_ready_i     (byte_ready_i),
    .reg_d_o          (reg_d_o),
    .reg_d_i          (reg_d_i),
    .reg_wr_o         (reg_wr_o),
    .reg_rd_o         (reg_rd_o),
    .spireg_cs_ctrl_o (spireg_cs_ctrl_o),
    .spireg_cs_stat_o (spireg_cs_stat_o),
    .spireg_cs_data_o (spireg_cs_data_o),
    .dbg_state_o      (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- host controller model ----------------
  // Each DATA write shifts one byte in: header slots return 8'hEE, data slot k returns 8'hA0+k.
  always @(posedge clk) begin
    logic [7:0] rxb;
    if (resetn) begin
      if (reg_wr_o || reg_rd_o) strobe_cnt++;
      if (reg_wr_o && spireg_cs_ctrl_o) begin
        ctrl_wr_log.push_back(reg_d_o);
        if (reg_d_o == 8'h01) data_wr_idx = 0;
      end
      if (reg_wr_o && spireg_cs_data_o) begin
        data_wr_log.push_back(reg_d_o);
        rxb = (data_wr_idx < HDR_LEN) ? 8'hEE : 8'(8'hA0 + (data_wr_idx - HDR_LEN));
        rx_q.push_back(rxb);
        data_wr_idx++;
        empty_left = stall_polls;
      end
      if (reg_rd_o && spireg_cs_stat_o) begin
        stat_rd_cnt++;
        if (dead || rx_q.size() == 0 || empty_left > 0) begin
          reg_d_i <= 8'hA1;
          if (empty_left > 0) empty_left--;
        end else begin
          reg_d_i <= 8'hA0;
        end
      end
      if (reg_rd_o && spireg_cs_data_o) reg_d_i <= (rx_q.size() > 0) ? rx_q.pop_front() : 8'h5A;
    end
  end

  // ---------------- consumer / done monitor ----------------
  always @(posedge clk) begin
    if (resetn && byte_valid_o && byte_ready_i) got_q.push_back(byte_o);
    if (resetn && done_o) done_cnt++;
  end

  // Register port shape: one-hot select with exactly one strobe, never two access cycles in a row.
  always @(negedge clk) begin
    if (resetn) begin
      checks++;
      if (reg_wr_o || reg_rd_o) begin
        if ((reg_wr_o && reg_rd_o) || !$onehot({spireg_cs_ctrl_o, spireg_cs_stat_o, spireg_cs_data_o}) || prev_strobe) begin
          failures++;
          $display("FAIL strobe_shape t=%0t wr=%b rd=%b cs=%b%b%b prev=%b required single strobe, one-hot cs, idle previous cycle",
                   $time, reg_wr_o, reg_rd_o, spireg_cs_ctrl_o, spireg_cs_stat_o, spireg_cs_data_o, prev_strobe);
        end
      end else if (spireg_cs_ctrl_o || spireg_cs_stat_o || spireg_cs_data_o) begin
        failures++;
        $display("FAIL cs_idle t=%0t cs=%b%b%b required 000", $time, spireg_cs_ctrl_o, spireg_cs_stat_o, spireg_cs_data_o);
      end
      prev_strobe = reg_wr_o || reg_rd_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    rx_q.delete();
    data_wr_log.delete();
    ctrl_wr_log.delete();
    got_q.delete();
    exp_q.delete();
    empty_left  = 0;
    stat_rd_cnt = 0;
    strobe_cnt  = 0;
    done_cnt    = 0;
  endtask

  task automatic do_start(input logic [23:0] a, input logic [15:0] l);
    @(negedge clk);
    start_i = 1'b1;
    addr_i  = a;
    len_i   = l;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic push_hdr(input logic [23:0] a);
    exp_q.push_back(OPC);
    exp_q.push_back(a[23:16]);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    if (HDR_LEN == 5) exp_q.push_back(8'h00);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    start_i = 0; addr_i = 0; len_i = 0; abort_i = 0; byte_ready_i = 0; reg_d_i = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, done_o, error_o, byte_valid_o, reg_wr_o, reg_rd_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got busy/done/err/valid/wr/rd=%b required 000000",
               {busy_o, done_o, error_o, byte_valid_o, reg_wr_o, reg_rd_o});
    end
    checks++;
    if ({byte_o, reg_d_o} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data got byte_o=%h reg_d_o=%h required 00 00", byte_o, reg_d_o);
    end
    checks++;
    if ({spireg_cs_ctrl_o, spireg_cs_stat_o, spireg_cs_data_o} !== 3'b000 || dbg_state_o !== 6'd0) begin
      failures++;
      $display("FAIL reset_state got cs=%b%b%b dbg=%h required 000 00",
               spireg_cs_ctrl_o, spireg_cs_stat_o, spireg_cs_data_o, dbg_state_o);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_read();
    bit ok;
    clear_logs();
    stall_polls  = 2;
    byte_ready_i = 1'b1;
    do_start(24'h012345, 16'd4);
    wait_idle(2000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout busy_o still high after 2000 cycles required idle"); end
    push_hdr(24'h012345);
    repeat (4) exp_q.push_back(8'h00);
    checks++;
    if (data_wr_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_data_wr_count got %0d required %0d", data_wr_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (data_wr_log[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL basic_data_wr[%0d] got %h required %h", i, data_wr_log[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (got_q.size() != 4 || got_q[0] !== 8'hA0 || got_q[1] !== 8'hA1 || got_q[2] !== 8'hA2 || got_q[3] !== 8'hA3) begin
      failures++;
      $display("FAIL basic_bytes got n=%0d %p required A0 A1 A2 A3", got_q.size(), got_q);
    end
    checks++;
    if (ctrl_wr_log.size() != 2 || ctrl_wr_log[0] !== 8'h01 || ctrl_wr_log[1] !== 8'h00) begin
      failures++;
      $display("FAIL basic_ctrl got %p required 01 00", ctrl_wr_log);
    end
    checks++;
    if (done_cnt != 1 || error_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got done_cnt=%0d error=%b required 1 0", done_cnt, error_o);
    end
  endtask

  task automatic test_len_zero();
    clear_logs();
    do_start(24'h000100, 16'd0);
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b1) begin
      failures++;
      $display("FAIL len0_first got busy=%b done=%b required 1 1", busy_o, done_o);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL len0_second got busy=%b done=%b required 0 0", busy_o, done_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (strobe_cnt != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL len0_strobes got strobes=%0d done_cnt=%0d required 0 1", strobe_cnt, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    int held_bad;
    clear_logs();
    stall_polls  = 0;
    byte_ready_i = 1'b1;
    do_start(24'h000200, 16'd3);
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (byte_valid_o && got_q.size() == 1) begin
        byte_ready_i = 1'b0;
        seen = 1;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL bp_second_byte second byte never presented required valid"); end
    held_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (byte_valid_o !== 1'b1 || byte_o !== 8'hA1 || data_wr_log.size() != HDR_LEN + 2) held_bad++;
    end
    checks++;
    if (held_bad != 0) begin
      failures++;
      $display("FAIL bp_hold bad cycles=%0d last valid=%b byte=%h data_wr=%0d required valid=1 byte=A1 data_wr=%0d",
               held_bad, byte_valid_o, byte_o, data_wr_log.size(), HDR_LEN + 2);
    end
    byte_ready_i = 1'b1;
    wait_idle(2000, ok);
    checks++;
    if (!ok || got_q.size() != 3 || got_q[0] !== 8'hA0 || got_q[1] !== 8'hA1 || got_q[2] !== 8'hA2 || done_cnt != 1) begin
      failures++;
      $display("FAIL bp_result ok=%b got %p done_cnt=%0d required A0 A1 A2 done 1", ok, got_q, done_cnt);
    end
  endtask

  task automatic test_poll_timeout();
    bit ok;
    clear_logs();
    dead = 1;
    byte_ready_i = 1'b1;
    do_start(24'h000300, 16'd2);
    wait_idle(6000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL to_timeout busy_o still high after 6000 cycles required idle"); end
    checks++;
    if (error_o !== 1'b1 || done_cnt != 0) begin
      failures++;
      $display("FAIL to_error got error=%b done_cnt=%0d required 1 0", error_o, done_cnt);
    end
    checks++;
    if (stat_rd_cnt != 1023) begin
      failures++;
      $display("FAIL to_polls got %0d required 1023", stat_rd_cnt);
    end
    checks++;
    if (ctrl_wr_log.size() != 2 || ctrl_wr_log[1] !== 8'h00) begin
      failures++;
      $display("FAIL to_ctrl got %p required 01 00", ctrl_wr_log);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (error_o !== 1'b1) begin failures++; $display("FAIL to_sticky got error=%b required 1", error_o); end
    dead = 0;
    clear_logs();
    do_start(24'h000310, 16'd1);
    checks++;
    if (error_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL to_clear got error=%b busy=%b required 0 1", error_o, busy_o);
    end
    wait_idle(2000, ok);
    checks++;
    if (!ok || got_q.size() != 1 || got_q[0] !== 8'hA0 || done_cnt != 1) begin
      failures++;
      $display("FAIL to_recover ok=%b got %p done_cnt=%0d required A0 done 1", ok, got_q, done_cnt);
    end
  endtask

  task automatic test_abort();
    bit ok;
    bit hit;
    clear_logs();
    abort_i = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || strobe_cnt != 0) begin
      failures++;
      $display("FAIL abort_idle got busy=%b strobes=%0d required 0 0", busy_o, strobe_cnt);
    end
    abort_i = 1'b0;
    byte_ready_i = 1'b1;
    stall_polls = 1;
    do_start(24'h000400, 16'd8);
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (data_wr_log.size() == HDR_LEN + 3) begin
        abort_i = 1'b1;
        hit = 1;
      end else begin
        @(negedge clk);
      end
    end
    wait_idle(500, ok);
    abort_i = 1'b0;
    checks++;
    if (!hit || !ok) begin failures++; $display("FAIL abort_reach hit=%b ok=%b required 1 1", hit, ok); end
    checks++;
    if (done_cnt != 0 || error_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_done got done_cnt=%0d error=%b required 0 0", done_cnt, error_o);
    end
    checks++;
    if (ctrl_wr_log.size() != 2 || ctrl_wr_log[1] !== 8'h00) begin
      failures++;
      $display("FAIL abort_ctrl got %p required 01 00", ctrl_wr_log);
    end
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'hA0 || got_q[1] !== 8'hA1) begin
      failures++;
      $display("FAIL abort_bytes got %p required A0 A1", got_q);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    stall_polls = 0;
    byte_ready_i = 1'b1;
    do_start(24'hABCDEF, 16'd2);
    repeat (10) @(negedge clk);
    start_i = 1'b1; addr_i = 24'h111111; len_i = 16'd0;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle(2000, ok);
    do_start(24'h000000, 16'd2);
    wait_idle(2000, ok);
    checks++;
    if (!ok || done_cnt != 2) begin
      failures++;
      $display("FAIL b2b_done ok=%b done_cnt=%0d required 1 2", ok, done_cnt);
    end
    push_hdr(24'hABCDEF);
    repeat (2) exp_q.push_back(8'h00);
    push_hdr(24'h000000);
    repeat (2) exp_q.push_back(8'h00);
    checks++;
    if (data_wr_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_data_wr_count got %0d required %0d", data_wr_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (data_wr_log[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL b2b_data_wr[%0d] got %h required %h", i, data_wr_log[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (got_q.size() != 4 || got_q[0] !== 8'hA0 || got_q[1] !== 8'hA1 || got_q[2] !== 8'hA0 || got_q[3] !== 8'hA1) begin
      failures++;
      $display("FAIL b2b_bytes got %p required A0 A1 A0 A1", got_q);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_read();
    test_len_zero();
    test_backpressure();
    test_poll_timeout();
    test_abort();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
